modexp_ctrl: RTL and testbench
==============================

# modexp_ctrl

Sequencer that computes base^exponent mod modulus by driving one shared `modmult` instance through its `ds`/`ready` handshake. It uses right-to-left binary square-and-multiply: one `modmult` operation is in flight at a time, and the intermediate values live in local registers. It sits between the RSA top-level (encrypt/decrypt request) and the `modmult` datapath. It holds that datapath's operand inputs stable for the whole of each operation.

## Interface
- `MPWID`, default 32: operand, modulus and result width in bits.

- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: request pulse; sampled only in IDLE.
- `base` in MPWID: message or cipher value; precondition `base < modulus`.
- `exponent` in MPWID: e or d.
- `modulus` in MPWID: n; precondition `modulus > 1`.
- `busy` out 1: high from the cycle after `start` is accepted through the DONE cycle.
- `done` out 1: one-cycle pulse when `result` becomes valid.
- `result` out MPWID: base^exponent mod modulus; held until the next accepted `start`.
- `mm_ds` out 1: one-cycle "data strobe" pulse to `modmult`.
- `mm_mpand` out MPWID: multiplicand to `modmult`.
- `mm_mplier` out MPWID: multiplier to `modmult`.
- `mm_modulus` out MPWID: modulus to `modmult`; this is the latched `modulus`.
- `mm_ready` in 1: `modmult` completion.
- `mm_product` in MPWID: `modmult` result.

## Operation
- Registers:
  - `acc`: running result.
  - `sq`: running base power.
  - `e`: remaining exponent.
  - `m`: latched modulus.
  - `op`: MUL or SQR.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - On `start`, latch `m <= modulus`, `sq <= base`, `e <= exponent`, `acc <= 1`.
  - If `exponent == 0`, go to DONE; the result is 1.
  - Otherwise select the first op: MUL if `exponent[0]`, else SQR. Go to ISSUE.
- ISSUE:
  - Assert `mm_ds` for exactly this cycle. Go to WAIT.
  - Operands for MUL: `mm_mpand = acc`, `mm_mplier = sq`.
  - Operands for SQR: `mm_mpand = sq`, `mm_mplier = sq`.
- WAIT:
  - Hold the operands unchanged.
  - `mm_ready` is ignored in the first WAIT cycle, because `modmult` may still show a stale ready.
  - Capture `mm_product` on the first later cycle with `mm_ready = 1`.
- Capture after MUL:
  - `acc <= mm_product`.
  - If `e[MPWID-1:1] == 0`, go to DONE; the final square is skipped.
  - Otherwise set `op <= SQR` and go to ISSUE.
- Capture after SQR:
  - `sq <= mm_product`, `e <= e >> 1`.
  - Next op is MUL if the new `e[0]` is 1, else SQR. Go to ISSUE.
  - After a SQR, the new `e` is nonzero, because the MUL-side check guarantees a higher set bit exists.
- DONE:
  - `result <= acc`, pulse `done`. Go to IDLE.
- `start` while not in IDLE is ignored. It is not queued.
- Operand contents are only defined while `busy`. `mm_mpand`, `mm_mplier` and `mm_modulus` are registered outputs.
- Operation count for exponent e: popcount(e) MULs plus (bit-length(e) − 1) SQRs.

## Timing
- Reset values: state IDLE; `busy`, `done` and `mm_ds` are 0; `result`, `acc`, `sq`, `e`, `m` and all `mm_*` operands are 0.
- Reset during any state, including WAIT with `modmult` mid-operation:
  - Return to IDLE next cycle with the reset values above.
  - A `mm_ready` that arrives after reset is ignored.
  - `modmult` is reset from the same `reset`.
- `start` is accepted at edge t0. `busy` is 1 from t0+1.
- Each op costs 1 ISSUE cycle plus WAIT cycles. WAIT lasts at least 2 cycles: the ignored cycle plus the `mm_ready` cycle.
- DONE takes 1 cycle. `done` and `result` are valid in the same cycle, and `busy` drops the cycle after.
- `exponent == 0` case: `done` pulses at t0+1, with no `mm_ds` pulses.
- A new `start` is accepted in the cycle after DONE, i.e. back-to-back requests are supported.

## Test plan
- **5^3 mod 13** (e = 0b11), behavioural `modmult` model with 4-cycle latency.
  - `result = 8`, `done` pulses exactly once.
  - Exactly 3 `mm_ds` pulses, in the order MUL, SQR, MUL.
- **4^13 mod 497**.
  - `result = 445`.
  - 6 `mm_ds` pulses: MUL, SQR, SQR, MUL, SQR, MUL.
  - Operands stay stable throughout every WAIT.
- **Boundary exponents**:
  - 7^0 mod 19 gives `result = 1`, `done` at t0+1, no `mm_ds`.
  - 7^1 mod 19 gives `result = 7` with one MUL.
  - 2^10 mod 1000 gives `result = 24`.
- **Stale ready**: the model holds `mm_ready = 1` through the first WAIT cycle.
  - The controller must not capture early.
  - 5^3 mod 13 still yields 8.
- **Reset mid-operation**: assert `reset` in the 2nd WAIT of 4^13 mod 497.
  - Next cycle: IDLE, `busy = 0`, `result = 0`, `mm_ds = 0`.
  - A new start of 2^10 mod 1000 then gives 24.
- **Ignored start**: pulse `start` with new operands while busy.
  - The first result is unaffected.
  - Back-to-back starts (second `start` in the cycle after `done`) both complete correctly.

Source files
------------

// File: rtl/modexp_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : modexp_ctrl_if
//  Description : Handshake/operand bundle between the modular-exponentiation
//                sequencer and the shared modmult datapath.
//  Revision    : 1.0  initial release
// ============================================================================
interface modexp_ctrl_if #(
  parameter int MPWID = 32
);
  logic             mm_ds;
  logic [MPWID-1:0] mm_mpand;
  logic [MPWID-1:0] mm_mplier;
  logic [MPWID-1:0] mm_modulus;
  logic             mm_ready;
  logic [MPWID-1:0] mm_product;

  // Sequencer side: issues operations, consumes products
  modport master (
    output mm_ds,
    output mm_mpand,
    output mm_mplier,
    output mm_modulus,
    input  mm_ready,
    input  mm_product
  );

  // modmult side: consumes operands, returns products
  modport slave (
    input  mm_ds,
    input  mm_mpand,
    input  mm_mplier,
    input  mm_modulus,
    output mm_ready,
    output mm_product
  );
endinterface
`default_nettype wire

// File: rtl/modexp_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : modexp_ctrl
//  Description : Right-to-left binary square-and-multiply sequencer computing
//                base^exponent mod modulus with one shared modmult unit.
//                One modmult operation is in flight at a time; operands are
//                registered and held stable for the whole operation.
//  Revision    : 1.0  initial release
// ============================================================================
module modexp_ctrl #(
  parameter int MPWID = 32
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             start,
  input  wire logic [MPWID-1:0] base,
  input  wire logic [MPWID-1:0] exponent,
  input  wire logic [MPWID-1:0] modulus,
  output logic                  busy,
  output logic                  done,
  output logic [MPWID-1:0]      result,
  modexp_ctrl_if.master         mm
);

  localparam logic [MPWID-1:0] c_one = {{(MPWID-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  typedef enum logic {
    OP_MUL = 1'b0,
    OP_SQR = 1'b1
  } op_t;

  state_t           state_q;
  op_t              op_q;
  logic [MPWID-1:0] acc_q;
  logic [MPWID-1:0] sq_q;
  logic [MPWID-1:0] e_q;
  logic [MPWID-1:0] m_q;
  logic [MPWID-1:0] mpand_q;
  logic [MPWID-1:0] mplier_q;
  logic [MPWID-1:0] result_q;
  logic             ds_q;
  logic             busy_q;
  logic             done_q;
  logic             first_wait_q;

  // A remaining exponent above 1 means a higher set bit still needs squaring
  logic e_more;
  assign e_more = (e_q > c_one);

  // Sequencer: latches the request, issues MUL/SQR ops and collects products
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      op_q         <= OP_MUL;
      acc_q        <= '0;
      sq_q         <= '0;
      e_q          <= '0;
      m_q          <= '0;
      mpand_q      <= '0;
      mplier_q     <= '0;
      result_q     <= '0;
      ds_q         <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      first_wait_q <= 1'b0;
    end else begin
      // Strobes are single-cycle unless re-armed below
      ds_q   <= 1'b0;
      done_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (start) begin
            m_q    <= modulus;
            sq_q   <= base;
            e_q    <= exponent;
            acc_q  <= c_one;
            busy_q <= 1'b1;
            if (exponent == '0) begin
              // x^0 = 1 without touching the multiplier
              result_q <= c_one;
              done_q   <= 1'b1;
              state_q  <= S_DONE;
            end else begin
              // Operands are loaded now so they are valid while ds is high
              if (exponent[0]) begin
                op_q    <= OP_MUL;
                mpand_q <= c_one;
              end else begin
                op_q    <= OP_SQR;
                mpand_q <= base;
              end
              mplier_q <= base;
              ds_q     <= 1'b1;
              state_q  <= S_ISSUE;
            end
          end
        end

        S_ISSUE: begin
          first_wait_q <= 1'b1;
          state_q      <= S_WAIT;
        end

        S_WAIT: begin
          if (first_wait_q) begin
            // modmult may still present the previous op's ready here
            first_wait_q <= 1'b0;
          end else if (mm.mm_ready) begin
            if (op_q == OP_MUL) begin
              acc_q <= mm.mm_product;
              if (!e_more) begin
                // No higher exponent bits: the trailing square is skipped
                result_q <= mm.mm_product;
                done_q   <= 1'b1;
                state_q  <= S_DONE;
              end else begin
                op_q     <= OP_SQR;
                mpand_q  <= sq_q;
                mplier_q <= sq_q;
                ds_q     <= 1'b1;
                state_q  <= S_ISSUE;
              end
            end else begin
              sq_q <= mm.mm_product;
              e_q  <= e_q >> 1;
              // e_q[1] becomes the new low bit after the shift
              if (e_q[1]) begin
                op_q     <= OP_MUL;
                mpand_q  <= acc_q;
                mplier_q <= mm.mm_product;
              end else begin
                op_q     <= OP_SQR;
                mpand_q  <= mm.mm_product;
                mplier_q <= mm.mm_product;
              end
              ds_q    <= 1'b1;
              state_q <= S_ISSUE;
            end
          end
        end

        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign result        = result_q;
  assign mm.mm_ds      = ds_q;
  assign mm.mm_mpand   = mpand_q;
  assign mm.mm_mplier  = mplier_q;
  assign mm.mm_modulus = m_q;

endmodule
`default_nettype wire

// File: tb/tb_modexp_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_modexp_ctrl
//  Description : Directed bench for modexp_ctrl with a behavioural modmult
//                model and a scoreboard of expected operands and results.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_modexp_ctrl;

  localparam int W   = 32;
  localparam int LAT = 4;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] m;
  } op_exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] base;
  logic [W-1:0] exponent;
  logic [W-1:0] modulus;
  logic         busy;
  logic         done;
  logic [W-1:0] result;

  modexp_ctrl_if #(.MPWID(W)) mm_bus ();

  modexp_ctrl #(.MPWID(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .base     (base),
    .exponent (exponent),
    .modulus  (modulus),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .mm       (mm_bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Behavioural modmult: LAT cycles after ds, ready rises with the product
  // and stays high until the next ds. In stale mode ready stays high (with a
  // junk product) through the cycle right after ds.
  logic         stale_mode = 1'b0;
  int           mcnt;
  logic [W-1:0] ma, mb, mmod;
  logic [63:0]  prod64;
  assign prod64 = ({32'b0, ma} * {32'b0, mb}) % {32'b0, mmod};

  always @(posedge clk) begin
    if (reset) begin
      mm_bus.mm_ready   <= 1'b0;
      mm_bus.mm_product <= '0;
      mcnt              <= 0;
    end else if (mm_bus.mm_ds) begin
      ma   <= mm_bus.mm_mpand;
      mb   <= mm_bus.mm_mplier;
      mmod <= mm_bus.mm_modulus;
      mcnt <= LAT;
      if (stale_mode) begin
        mm_bus.mm_ready   <= 1'b1;
        mm_bus.mm_product <= 32'hDEAD_BEEF;
      end else begin
        mm_bus.mm_ready   <= 1'b0;
      end
    end else if (mcnt > 0) begin
      mcnt <= mcnt - 1;
      if (mcnt == 1) begin
        mm_bus.mm_ready   <= 1'b1;
        mm_bus.mm_product <= prod64[W-1:0];
      end else begin
        mm_bus.mm_ready   <= 1'b0;
      end
    end
  end

  // Scoreboard
  op_exp_t      exp_op_q[$];
  logic [W-1:0] exp_res_q[$];
  int           ds_seen   = 0;
  int           done_seen = 0;
  logic         in_op     = 1'b0;
  logic         unstable  = 1'b0;
  logic [W-1:0] ra, rb, rm;

  always @(negedge clk) begin
    if (reset) begin
      in_op = 1'b0;
    end else begin
      if (in_op) begin
        if (mm_bus.mm_mpand !== ra || mm_bus.mm_mplier !== rb || mm_bus.mm_modulus !== rm)
          unstable = 1'b1;
        if (mm_bus.mm_ready && mcnt == 0) begin
          chk("op_stable", unstable, 0);
          in_op = 1'b0;
        end
      end
      if (mm_bus.mm_ds) begin
        op_exp_t e;
        ds_seen++;
        chk("ds_expected", exp_op_q.size() != 0, 1);
        if (exp_op_q.size() != 0) begin
          e = exp_op_q.pop_front();
          chk("mm_mpand", mm_bus.mm_mpand, e.a);
          chk("mm_mplier", mm_bus.mm_mplier, e.b);
          chk("mm_modulus", mm_bus.mm_modulus, e.m);
        end
        ra       = mm_bus.mm_mpand;
        rb       = mm_bus.mm_mplier;
        rm       = mm_bus.mm_modulus;
        in_op    = 1'b1;
        unstable = 1'b0;
      end
      if (done) begin
        done_seen++;
        chk("done_expected", exp_res_q.size() != 0, 1);
        if (exp_res_q.size() != 0)
          chk("result", result, exp_res_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] m);
    op_exp_t e;
    e.a = a; e.b = b; e.m = m;
    exp_op_q.push_back(e);
  endtask

  task automatic do_start(input logic [W-1:0] b, input logic [W-1:0] e, input logic [W-1:0] m);
    tick();
    base = b; exponent = e; modulus = m; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int d0);
    int n = 0;
    while (done_seen == d0 && n < 500) begin
      tick();
      n++;
    end
    chk(tag, done_seen != d0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, s0, n;
    reset = 1'b1; start = 1'b0; base = '0; exponent = '0; modulus = '0;
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_ds", mm_bus.mm_ds, 0);
    chk("rst_mpand", mm_bus.mm_mpand, 0);
    chk("rst_mplier", mm_bus.mm_mplier, 0);
    chk("rst_modulus", mm_bus.mm_modulus, 0);
    reset = 1'b0;
    tick();

    // 5^3 mod 13 : MUL, SQR, MUL
    push_op(1, 5, 13); push_op(5, 5, 13); push_op(5, 12, 13);
    exp_res_q.push_back(8);
    d0 = done_seen; s0 = ds_seen;
    do_start(5, 3, 13);
    chk("t1_busy_after_start", busy, 1);
    wait_done("t1_done_timeout", d0);
    tick();
    chk("t1_busy_drop", busy, 0);
    repeat (3) tick();
    chk("t1_done_count", done_seen - d0, 1);
    chk("t1_ds_count", ds_seen - s0, 3);

    // 4^13 mod 497 : MUL, SQR, SQR, MUL, SQR, MUL
    push_op(1, 4, 497); push_op(4, 4, 497); push_op(16, 16, 497);
    push_op(4, 256, 497); push_op(256, 256, 497); push_op(30, 429, 497);
    exp_res_q.push_back(445);
    d0 = done_seen; s0 = ds_seen;
    do_start(4, 13, 497);
    wait_done("t2_done_timeout", d0);
    chk("t2_ds_count", ds_seen - s0, 6);

    // 7^0 mod 19 : done at t0+1, no ds
    exp_res_q.push_back(1);
    d0 = done_seen; s0 = ds_seen;
    do_start(7, 0, 19);
    chk("t3_done_t0p1", done, 1);
    chk("t3_result_t0p1", result, 1);
    tick();
    chk("t3_busy_drop", busy, 0);
    chk("t3_ds_count", ds_seen - s0, 0);

    // 7^1 mod 19 : single MUL
    push_op(1, 7, 19);
    exp_res_q.push_back(7);
    d0 = done_seen; s0 = ds_seen;
    do_start(7, 1, 19);
    wait_done("t4_done_timeout", d0);
    chk("t4_ds_count", ds_seen - s0, 1);

    // 2^10 mod 1000 : SQR, MUL, SQR, SQR, MUL
    push_op(2, 2, 1000); push_op(1, 4, 1000); push_op(4, 4, 1000);
    push_op(16, 16, 1000); push_op(4, 256, 1000);
    exp_res_q.push_back(24);
    d0 = done_seen; s0 = ds_seen;
    do_start(2, 10, 1000);
    wait_done("t5_done_timeout", d0);
    chk("t5_ds_count", ds_seen - s0, 5);

    // Stale ready through the first WAIT cycle
    stale_mode = 1'b1;
    push_op(1, 5, 13); push_op(5, 5, 13); push_op(5, 12, 13);
    exp_res_q.push_back(8);
    d0 = done_seen;
    do_start(5, 3, 13);
    wait_done("t6_done_timeout", d0);
    stale_mode = 1'b0;
    tick();

    // Reset during the 2nd WAIT cycle of 4^13 mod 497
    push_op(1, 4, 497);
    s0 = ds_seen;
    do_start(4, 13, 497);
    n = 0;
    while (ds_seen == s0 && n < 20) begin
      tick();
      n++;
    end
    chk("t7_first_ds", ds_seen - s0, 1);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t7_busy", busy, 0);
    chk("t7_result", result, 0);
    chk("t7_ds", mm_bus.mm_ds, 0);
    chk("t7_done", done, 0);
    chk("t7_ops_left", exp_op_q.size(), 0);
    s0 = ds_seen;
    repeat (8) tick();
    chk("t7_idle_no_ds", ds_seen - s0, 0);
    push_op(2, 2, 1000); push_op(1, 4, 1000); push_op(4, 4, 1000);
    push_op(16, 16, 1000); push_op(4, 256, 1000);
    exp_res_q.push_back(24);
    d0 = done_seen;
    do_start(2, 10, 1000);
    wait_done("t7_done_timeout", d0);

    // start while busy is ignored
    push_op(1, 4, 497); push_op(4, 4, 497); push_op(16, 16, 497);
    push_op(4, 256, 497); push_op(256, 256, 497); push_op(30, 429, 497);
    exp_res_q.push_back(445);
    d0 = done_seen; s0 = ds_seen;
    do_start(4, 13, 497);
    repeat (3) tick();
    base = 3; exponent = 5; modulus = 7; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("t8_done_timeout", d0);
    chk("t8_ds_count", ds_seen - s0, 6);
    repeat (3) tick();
    chk("t8_done_count", done_seen - d0, 1);

    // Back-to-back: second start in the cycle after done
    push_op(1, 7, 19);
    exp_res_q.push_back(7);
    push_op(1, 5, 13); push_op(5, 5, 13); push_op(5, 12, 13);
    exp_res_q.push_back(8);
    d0 = done_seen; s0 = ds_seen;
    do_start(7, 1, 19);
    wait_done("t9a_done_timeout", d0);
    d0 = done_seen;
    do_start(5, 3, 13);
    chk("t9_second_accepted", busy, 1);
    wait_done("t9b_done_timeout", d0);
    chk("t9_ds_count", ds_seen - s0, 4);
    repeat (3) tick();

    chk("end_results_left", exp_res_q.size(), 0);
    chk("end_ops_left", exp_op_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
